systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream stage of systolic_2: buffers an input matrix row by row, then on command streams it into the array's x01..x04 inputs.
- Generates the one-cycle start pulse aligned with the first row, and optionally applies the diagonal input skew.
- Signals busy/done around each matrix pass, and holds the array inputs at zero while it drains.

Parameters:
DW, 32, data width of one matrix element / one array lane
ROWS, 10, maximum rows per matrix (buffer depth)
AW, 4, row-counter/address width; must satisfy 2**AW >= ROWS+1
SKEW, 0, 0 = all four lanes aligned; 1 = lane k delayed by k-1 cycles
FLUSH, 50, zero-input cycles after the last element before done (array drain time)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  upstream row valid
in_ready  output  1  feeder can accept a row this cycle
in_row  input  4*DW  one matrix row; lane1 in bits [DW-1:0], lane4 in bits [4*DW-1:3*DW]
in_last  input  1  qualifies the final row of the matrix (sampled with in_valid&&in_ready)
go  input  1  begin streaming a loaded matrix
start  output  1  one-cycle pulse to systolic_2.start
x01  output  DW  array lane 1 input
x02  output  DW  array lane 2 input
x03  output  DW  array lane 3 input
x04  output  DW  array lane 4 input
busy  output  1  high from go acceptance until done
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (rst=0, async): state=LOAD, row count n=0, start=0, x01..x04=0, busy=0, done=0, in_ready=1 once reset is released. Buffer RAM contents are not reset.
- All outputs are registered.
- FSM states:
  - LOAD: in_ready=1. A row is accepted on in_valid&&in_ready and written to buf[n], then n++. Go to LOADED when the accepted row has in_last=1, or when n reaches ROWS (auto-close; in_last is ignored on that row).
  - LOADED: in_ready=0, holds until go=1.
  - STREAM: entered the cycle after go. busy=1 from that same edge.
    - On the first STREAM cycle, start=1 and lane k presents buf[0] (SKEW=0).
    - Row i appears on cycle i of STREAM. start=0 on all later cycles.
    - STREAM lasts n+3*SKEW cycles.
  - DRAIN: x01..x04=0 for FLUSH cycles, then done=1 for one cycle, busy=0, n=0, return to LOAD.
- SKEW=1:
  - Lane k outputs buf[i] lane k on STREAM cycle i+k-1.
  - Lane k outputs 0 on STREAM cycles before k-1 and after n+k-2.
  - start is still coincident with STREAM cycle 0.
- Outside STREAM, x01..x04=0.
- go is ignored in LOAD, STREAM and DRAIN; it is not queued.
- in_valid in any state other than LOAD is not accepted (in_ready=0); no row is lost or written.
- in_last on an empty buffer (first row) gives n=1, a valid single-row pass.
- go and the closing in_last in the same cycle: go is ignored (state was LOAD).
- Reset mid-STREAM/DRAIN:
  - Outputs go to 0 immediately and start does not pulse.
  - done does not pulse.
  - The matrix is discarded (n=0).
- Data passes unmodified. No arithmetic on data beyond counters. Counters saturate-free: n never exceeds ROWS.

Test Plan:
- Load 10 rows (row i lane k = 32'h000k_000i, in_last on i=9), SKEW=0, pulse go -> next cycle start=1 with x01=32'h0001_0000 and x04=32'h0004_0000. Cycle 9 gives x03=32'h0003_0009. Cycle 10 gives all lanes 0. done pulses exactly 10+FLUSH cycles after start, then in_ready=1.
- Same matrix, SKEW=1 -> x04 is 0 on cycles 0-2 and 32'h0004_0000 on cycle 3. x02 ends with 32'h0002_0009 on cycle 10. STREAM lasts 13 cycles. start is high on cycle 0 only.
- 4 rows with in_last on the 4th -> n=4. go gives start plus 4 data cycles then zeros. Present an 11-row burst without in_last -> in_ready drops after the 10th acceptance, and the 11th row is held by upstream, not written.
- Pulse go during LOAD (n=3) and again during STREAM -> no start and no state change on either. Only the go issued in LOADED starts a pass.
- Assert rst=0 on STREAM cycle 5 -> x01..x04=0 and busy=0 within the same cycle (async), no done. After release, in_ready=1 and a fresh 2-row load streams correctly.
- Toggle in_valid with gaps (rows on alternate cycles) -> all rows are stored in order; the streamed sequence matches the input order exactly.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: row buffer in front of systolic_2.
// Collects a matrix one row at a time, then on go streams it into the
// array lanes x01..x04 with a start pulse on the first row, optionally
// skewing lane k by k-1 cycles. It then holds the lanes at zero while the
// array drains, and pulses done.
module systolic_feeder #(
    parameter int DW    = 32,
    parameter int ROWS  = 10,
    parameter int AW    = 4,
    parameter int SKEW  = 0,
    parameter int FLUSH = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_row,
    input  logic            in_last,
    input  logic            go,
    output logic            start,
    output logic [DW-1:0]   x01,
    output logic [DW-1:0]   x02,
    output logic [DW-1:0]   x03,
    output logic [DW-1:0]   x04,
    output logic            busy,
    output logic            done
);

    // The stream counter must reach ROWS+3 when skewed, so it gets one extra bit
    localparam int CW = AW + 1;
    localparam int FW = (FLUSH < 1) ? 1 : $clog2(FLUSH + 1);

    localparam logic [CW-1:0] STREAM_EXTRA = (SKEW != 0) ? CW'(3) : '0;
    localparam logic [AW-1:0] ROWS_L       = AW'(ROWS);
    localparam logic [FW-1:0] FLUSH_L      = FW'(FLUSH);

    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] LOADED = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]      state;
    logic [AW-1:0]   n;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   dcnt;
    logic [4*DW-1:0] mem [ROWS];

    logic            accept;
    logic [CW-1:0]   stream_len;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   off;
    logic [AW-1:0]   row;
    logic [DW-1:0]   lane_next [4];

    assign accept     = in_valid && in_ready && (state == LOAD);
    assign stream_len = {1'b0, n} + STREAM_EXTRA;

    // The go edge presents stream cycle 0; later edges present cycle cnt
    assign idx = (state == STREAM) ? cnt : '0;

    // Choose which buffered row each lane shows on the next stream cycle
    always_comb begin
        off = '0;
        row = '0;
        for (int k = 0; k < 4; k++) begin
            lane_next[k] = '0;
            off = (SKEW != 0) ? CW'(k) : '0;
            if ((idx >= off) && ((idx - off) < {1'b0, n})) begin
                row = AW'(idx - off);
                lane_next[k] = mem[row][k*DW +: DW];
            end
        end
    end

    // Row buffer: plain storage, contents deliberately left unreset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[n] <= in_row;
        end
    end

    // Load / wait / stream / drain sequencing with fully registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD;
            n        <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            in_ready <= 1'b1;
            start    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x01      <= '0;
            x02      <= '0;
            x03      <= '0;
            x04      <= '0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        n <= n + AW'(1);
                        if (in_last || ((n + AW'(1)) == ROWS_L)) begin
                            state    <= LOADED;
                            in_ready <= 1'b0;
                        end
                    end
                end
                LOADED: begin
                    if (go) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                        start <= 1'b1;
                        cnt   <= CW'(1);
                        x01   <= lane_next[0];
                        x02   <= lane_next[1];
                        x03   <= lane_next[2];
                        x04   <= lane_next[3];
                    end
                end
                STREAM: begin
                    if (cnt == stream_len) begin
                        state <= DRAIN;
                        dcnt  <= FW'(1);
                        x01   <= '0;
                        x02   <= '0;
                        x03   <= '0;
                        x04   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        x01 <= lane_next[0];
                        x02 <= lane_next[1];
                        x03 <= lane_next[2];
                        x04 <= lane_next[3];
                    end
                end
                DRAIN: begin
                    if (dcnt >= FLUSH_L) begin
                        state    <= LOAD;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        n        <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        dcnt <= dcnt + FW'(1);
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: drives one aligned and one skewed feeder from the same
// stimulus. Every pass pushes the expected per-cycle output records into a
// queue per instance; a negedge monitor pops and compares whenever an
// instance shows busy or done.
module tb_systolic_feeder;

    localparam int DW    = 32;
    localparam int ROWS  = 10;
    localparam int AW    = 4;
    localparam int FLUSH = 12;
    localparam int RW    = 4*DW + 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [4*DW-1:0] in_row;
    logic            in_last;
    logic            go;

    logic            in_ready0, start0, busy0, done0;
    logic [DW-1:0]   x01_0, x02_0, x03_0, x04_0;
    logic            in_ready1, start1, busy1, done1;
    logic [DW-1:0]   x01_1, x02_1, x03_1, x04_1;

    logic [RW-1:0]   q0[$];
    logic [RW-1:0]   q1[$];
    int              n_checks;
    int              n_fails;

    systolic_feeder #(.DW(DW), .ROWS(ROWS), .AW(AW), .SKEW(0), .FLUSH(FLUSH)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_row(in_row), .in_last(in_last), .go(go), .start(start0),
        .x01(x01_0), .x02(x02_0), .x03(x03_0), .x04(x04_0),
        .busy(busy0), .done(done0)
    );

    systolic_feeder #(.DW(DW), .ROWS(ROWS), .AW(AW), .SKEW(1), .FLUSH(FLUSH)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_row(in_row), .in_last(in_last), .go(go), .start(start1),
        .x01(x01_1), .x02(x02_1), .x03(x03_1), .x04(x04_1),
        .busy(busy1), .done(done1)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] base, input int i, input int k);
        return base | (DW'(k) << 16) | DW'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected records {start, done, x01, x02, x03, x04} for a whole pass
    task automatic push_pass(input logic [DW-1:0] base, input int n);
        int len;
        int r_idx;
        logic [RW-1:0] r;
        for (int s = 0; s < 2; s++) begin
            len = n + 3*s;
            for (int c = 0; c < len + FLUSH + 1; c++) begin
                r = '0;
                if (c < len) begin
                    r[RW-1] = (c == 0);
                    for (int k = 1; k <= 4; k++) begin
                        r_idx = c - ((s != 0) ? (k - 1) : 0);
                        if (r_idx >= 0 && r_idx < n) begin
                            r[(4-k)*DW +: DW] = pat(base, r_idx, k);
                        end
                    end
                end else if (c == len + FLUSH) begin
                    r[RW-2] = 1'b1;
                end
                if (s == 0) q0.push_back(r);
                else        q1.push_back(r);
            end
        end
    endtask

    task automatic drive_row(input logic [DW-1:0] base, input int i, input logic last, input logic with_go);
        in_valid = 1'b1;
        in_row   = {pat(base, i, 4), pat(base, i, 3), pat(base, i, 2), pat(base, i, 1)};
        in_last  = last;
        go       = with_go;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        go       = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic check_ready(input string name, input logic exp);
        check_output({name, "_rdy0"}, RW'(in_ready0), RW'(exp));
        check_output({name, "_rdy1"}, RW'(in_ready1), RW'(exp));
    endtask

    task automatic load_rows(input string name, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            check_ready(name, 1'b1);
            drive_row(base, i, (i == n - 1), 1'b0);
        end
        check_ready({name, "_closed"}, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && in_ready0 && in_ready1) && cyc < 200) begin
            tick();
            cyc++;
        end
        check_output(name, RW'(q0.size() == 0 && q1.size() == 0 && in_ready0 && in_ready1), RW'(1));
    endtask

    task automatic sb_unexpected(input string name, input logic [RW-1:0] act);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: got output %h with no record queued, required idle", name, act);
    endtask

    // Scoreboard monitor for the aligned instance
    always @(negedge clk) begin
        if (rst && (busy0 || done0)) begin
            if (q0.size() == 0) sb_unexpected("sb0_unexpected", {start0, done0, x01_0, x02_0, x03_0, x04_0});
            else check_output("sb0_cycle", {start0, done0, x01_0, x02_0, x03_0, x04_0}, q0.pop_front());
        end
    end

    // Scoreboard monitor for the skewed instance
    always @(negedge clk) begin
        if (rst && (busy1 || done1)) begin
            if (q1.size() == 0) sb_unexpected("sb1_unexpected", {start1, done1, x01_1, x02_1, x03_1, x04_1});
            else check_output("sb1_cycle", {start1, done1, x01_1, x02_1, x03_1, x04_1}, q1.pop_front());
        end
    end

    // Directed test sequence
    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        in_last  = 1'b0;
        go       = 1'b0;

        // Reset state
        repeat (3) tick();
        check_output("rst_outs0", {start0, done0, busy0, x01_0, x02_0, x03_0, x04_0}, '0);
        check_output("rst_outs1", {start1, done1, busy1, x01_1, x02_1, x03_1, x04_1}, '0);
        rst = 1'b1;
        tick();
        check_ready("after_rst", 1'b1);

        // Full 10-row matrix, both skews, with spot checks
        load_rows("t10", 32'h0, 10);
        push_pass(32'h0, 10);
        pulse_go();
        check_output("c0_start0", RW'(start0), RW'(1));
        check_output("c0_x01_0", RW'(x01_0), RW'(32'h0001_0000));
        check_output("c0_x04_0", RW'(x04_0), RW'(32'h0004_0000));
        check_output("c0_start1", RW'(start1), RW'(1));
        check_output("c0_x04_1", RW'(x04_1), RW'(32'h0));
        repeat (3) tick();
        check_output("c3_x04_1", RW'(x04_1), RW'(32'h0004_0000));
        check_output("c3_start1", RW'(start1), RW'(0));
        repeat (6) tick();
        check_output("c9_x03_0", RW'(x03_0), RW'(32'h0003_0009));
        tick();
        check_output("c10_lanes0", RW'({x01_0, x02_0, x03_0, x04_0}), RW'(0));
        check_output("c10_x02_1", RW'(x02_1), RW'(32'h0002_0009));
        repeat (2) tick();
        check_output("c12_x04_1", RW'(x04_1), RW'(32'h0004_0009));
        wait_idle("t10_idle");

        // go in LOAD ignored, go together with closing in_last ignored
        for (int i = 0; i < 3; i++) drive_row(32'h1000_0000, i, 1'b0, 1'b0);
        pulse_go();
        check_output("go_in_load_busy", RW'({busy0, busy1}), RW'(0));
        check_ready("go_in_load", 1'b1);
        drive_row(32'h1000_0000, 3, 1'b1, 1'b1);
        check_output("go_with_last_busy", RW'({busy0, busy1, start0, start1}), RW'(0));
        check_ready("go_with_last", 1'b0);
        repeat (2) tick();
        check_output("loaded_hold_busy", RW'({busy0, busy1}), RW'(0));
        push_pass(32'h1000_0000, 4);
        pulse_go();
        check_output("t4_busy", RW'({busy0, busy1}), RW'(2'b11));
        repeat (2) tick();
        pulse_go();
        wait_idle("t4_idle");

        // 11-row burst without in_last: auto-close after ten rows
        for (int i = 0; i < 11; i++) begin
            check_ready("burst", (i < 10));
            in_valid = 1'b1;
            in_row   = {pat(32'h2000_0000, i, 4), pat(32'h2000_0000, i, 3),
                        pat(32'h2000_0000, i, 2), pat(32'h2000_0000, i, 1)};
            tick();
        end
        check_ready("burst_held", 1'b0);
        in_valid = 1'b0;
        push_pass(32'h2000_0000, 10);
        pulse_go();
        wait_idle("burst_idle");

        // Rows on alternate cycles
        for (int i = 0; i < 6; i++) begin
            drive_row(32'h3000_0000, i, (i == 5), 1'b0);
            tick();
        end
        check_ready("gaps_closed", 1'b0);
        push_pass(32'h3000_0000, 6);
        pulse_go();
        wait_idle("gaps_idle");

        // Asynchronous reset on stream cycle 5
        load_rows("rst_mid", 32'h4000_0000, 10);
        push_pass(32'h4000_0000, 10);
        pulse_go();
        repeat (5) tick();
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_outs0", {start0, done0, busy0, x01_0, x02_0, x03_0, x04_0}, '0);
        check_output("midrst_outs1", {start1, done1, busy1, x01_1, x02_1, x03_1, x04_1}, '0);
        q0.delete();
        q1.delete();
        repeat (2) tick();
        rst = 1'b1;
        check_ready("midrst_release", 1'b1);
        repeat (FLUSH + 20) tick();
        check_ready("midrst_quiet", 1'b1);
        load_rows("fresh", 32'h5000_0000, 2);
        push_pass(32'h5000_0000, 2);
        pulse_go();
        wait_idle("fresh_idle");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
